// File: rtl/pipe_stage.sv
// Pipeline register stage with valid/ready handshake, optional two-entry skid
// buffer, exception flush and saturating stall/bubble performance counters.
module pipe_stage #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] head_data, head_data_next, skid_data, skid_data_next;
    logic [EXC_W-1:0]  head_exc, head_exc_next, skid_exc, skid_exc_next;
    logic              in_fire, out_fire;

    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    assign out_exc   = head_exc;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // With the skid buffer in_ready depends only on registered state.
    always_comb begin
        if (SKID != 0) begin
            in_ready = (state != TWO);
        end else begin
            in_ready = (state == EMPTY) | out_ready;
        end
    end

    always_comb begin
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_next     = state;
        head_data_next = head_data;
        head_exc_next  = head_exc;
        skid_data_next = skid_data;
        skid_exc_next  = skid_exc;
        if (flush) begin
            state_next     = EMPTY;
            head_data_next = '0;
            head_exc_next  = '0;
            skid_data_next = '0;
            skid_exc_next  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next     = ONE;
                        head_data_next = in_data;
                        head_exc_next  = in_exc;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_data_next = in_data;
                        head_exc_next  = in_exc;
                    end else if (in_fire) begin
                        // Only reachable with the skid buffer present.
                        state_next     = TWO;
                        skid_data_next = in_data;
                        skid_exc_next  = in_exc;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next     = ONE;
                        head_data_next = skid_data;
                        head_exc_next  = skid_exc;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_data <= '0;
            head_exc  <= '0;
            skid_data <= '0;
            skid_exc  <= '0;
        end else begin
            state     <= state_next;
            head_data <= head_data_next;
            head_exc  <= head_exc_next;
            skid_data <= skid_data_next;
            skid_exc  <= skid_exc_next;
        end
    end

    // Counters sample the pre-edge handshake and ignore flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (!out_valid && out_ready && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a skid instance (CNT_W=4) and a no-skid instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data, in_exc;

    logic        ir0, ov0, ir1, ov1;
    logic [31:0] od0, oe0, od1, oe1;
    logic [1:0]  occ0, occ1;
    logic [3:0]  bc0, sc0;
    logic [15:0] bc1, sc1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef logic [63:0] beat_q_t[$];
    beat_q_t     mq[2];
    logic [63:0] mlast[2];
    int unsigned mbub[2], mstall[2];

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(32), .EXC_W(32), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_exc(in_exc),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_exc(oe0),
        .occupancy(occ0), .bubble_cnt(bc0), .stall_cnt(sc0)
    );

    pipe_stage #(.DATA_W(32), .EXC_W(32), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_exc(in_exc),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_exc(oe1),
        .occupancy(occ1), .bubble_cnt(bc1), .stall_cnt(sc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_ready(input int k);
        if (k == 0) return mq[0].size() < 2;
        return (mq[1].size() == 0) || out_ready;
    endfunction

    task automatic compare_all();
        logic [63:0] eb;
        logic [31:0] a_ir, a_ov, a_od, a_oe, a_occ, a_bc, a_sc;
        for (int k = 0; k < 2; k++) begin
            eb = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
            if (k == 0) begin
                a_ir = 32'(ir0); a_ov = 32'(ov0); a_od = od0; a_oe = oe0;
                a_occ = 32'(occ0); a_bc = 32'(bc0); a_sc = 32'(sc0);
            end else begin
                a_ir = 32'(ir1); a_ov = 32'(ov1); a_od = od1; a_oe = oe1;
                a_occ = 32'(occ1); a_bc = 32'(bc1); a_sc = 32'(sc1);
            end
            chk($sformatf("d%0d in_ready", k), a_ir, 32'(m_ready(k)));
            chk($sformatf("d%0d out_valid", k), a_ov, 32'(mq[k].size() != 0));
            chk($sformatf("d%0d out_data", k), a_od, eb[31:0]);
            chk($sformatf("d%0d out_exc", k), a_oe, eb[63:32]);
            chk($sformatf("d%0d occupancy", k), a_occ, 32'(mq[k].size()));
            chk($sformatf("d%0d bubble_cnt", k), a_bc, mbub[k]);
            chk($sformatf("d%0d stall_cnt", k), a_sc, mstall[k]);
        end
    endtask

    task automatic model_step();
        bit          rdy, ov;
        int unsigned cmax;
        for (int k = 0; k < 2; k++) begin
            rdy  = m_ready(k);
            ov   = mq[k].size() != 0;
            cmax = (k == 0) ? 15 : 65535;
            if (rst) begin
                mbub[k]   = 0;
                mstall[k] = 0;
            end else begin
                if (!ov && out_ready && mbub[k] < cmax) mbub[k]++;
                if (ov && !out_ready && mstall[k] < cmax) mstall[k]++;
            end
            if (rst || flush) begin
                mq[k].delete();
                mlast[k] = '0;
            end else begin
                if (ov && out_ready) mlast[k] = mq[k].pop_front();
                if (in_valid && rdy) mq[k].push_back({in_exc, in_data});
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        in_exc    = d ^ 32'hFFFF_0000;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            mq[k].delete(); mlast[k] = '0; mbub[k] = 0; mstall[k] = 0;
        end
        @(posedge clk);
        model_step();
        #1;
        cycle();
        rst = 1'b0;
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid", 32'(ov0), 32'd0);

        // Back-to-back stream with downstream always ready.
        drive(1'b1, 32'h1000, 1'b1); cycle();
        drive(1'b1, 32'h1004, 1'b1); cycle();
        chk("stream out_data", od0, 32'h1004);
        chk("stream occupancy", 32'(occ0), 32'd1);
        drive(1'b1, 32'h1008, 1'b1); cycle();
        chk("stream out_data2", od0, 32'h1008);
        chk("stream stall_cnt", 32'(sc0), 32'd0);

        // Bubble counter saturation, then cleared by reset.
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) cycle();
        chk("bubble saturate", 32'(bc0), 32'd15);
        chk("hold last data", od0, 32'h1008);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("bubble after rst", 32'(bc0), 32'd0);

        // Fill the skid buffer under backpressure.
        drive(1'b1, 32'hA, 1'b0); cycle();
        drive(1'b1, 32'hB, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("two occupancy", 32'(occ0), 32'd2);
        chk("two in_ready", 32'(ir0), 32'd0);
        chk("two stall_cnt", 32'(sc0), 32'd4);
        chk("noskid full in_ready", 32'(ir1), 32'd0);
        out_ready = 1'b1; #1;
        chk("noskid comb in_ready", 32'(ir1), 32'd1);
        drive(1'b1, 32'hD, 1'b1); cycle();
        chk("noskid replace head", od1, 32'hD);
        chk("skid drain first", od0, 32'hB);
        chk("skid in_ready back", 32'(ir0), 32'd1);
        drive(1'b0, 32'h0, 1'b1); cycle(); cycle();
        chk("skid empty hold", od0, 32'hB);
        chk("skid empty valid", 32'(ov0), 32'd0);

        // Flush in TWO with a simultaneous offer and ready.
        drive(1'b1, 32'hA, 1'b0); cycle();
        drive(1'b1, 32'hB, 1'b0); cycle();
        flush = 1'b1;
        drive(1'b1, 32'hC, 1'b1); cycle();
        flush = 1'b0;
        chk("flush out_valid", 32'(ov0), 32'd0);
        chk("flush out_data", od0, 32'd0);
        chk("flush out_exc", oe0, 32'd0);
        chk("flush occupancy", 32'(occ0), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        chk("flush no C", 32'(ov0), 32'd0);

        // Reset mid-stream with an offered beat.
        drive(1'b1, 32'h55, 1'b0); cycle();
        rst = 1'b1;
        drive(1'b1, 32'h66, 1'b0); cycle();
        rst = 1'b0;
        chk("rst occupancy", 32'(occ0), 32'd0);
        chk("rst stall_cnt", 32'(sc0), 32'd0);
        chk("rst out_data", od0, 32'd0);

        // Randomised traffic with varying backpressure.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 3 + (i / 500));
            in_data   = $urandom;
            in_exc    = $urandom;
            cycle();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
